// File: rtl/phy_pkg.sv
// Shared sizing helpers and word type for the PHY skid pipeline.
// Imported by the stage and the top-level wrapper.
package phy_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int STAGES_DEF = 2;

  // Counter must represent 0..2*stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
  } phy_word_t;

endpackage

// File: rtl/phy_skid_stage.sv
// One registered valid/ready stage: a main register feeding downstream and a
// skid register that absorbs one word while main is stalled.
module phy_skid_stage
  import phy_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i
);

  logic              main_v_q,    main_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q,    skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              ready_q,     ready_d;
  logic              in_fire_s;
  logic              out_fire_s;

  // Next-state selection for main/skid registers and the upstream ready.
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    in_fire_s   = valid_i & ready_q;
    out_fire_s  = main_v_q & ready_i;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = '0;
      skid_v_d    = 1'b0;
      skid_data_d = '0;
    end else if (!main_v_q || out_fire_s) begin
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        skid_v_d    = in_fire_s;
        skid_data_d = in_fire_s ? data_i : skid_data_q;
      end else if (in_fire_s) begin
        main_v_d    = 1'b1;
        main_data_d = data_i;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_v_d    = 1'b1;
      skid_data_d = data_i;
    end else begin
      skid_v_d    = skid_v_q;
    end
    // Ready is registered from the next skid state, so upstream never sees a comb path.
    ready_d = ~skid_v_d;
  end

  // State registers; ready stays low in reset and rises on the first edge after release.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = main_v_q;
  assign data_o  = main_data_q;

endmodule

// File: rtl/phy_skid_pipe.sv
// STAGES cascaded skid stages on clk_2f with flush fan-out and a word occupancy
// counter covering everything held between data_in and data_out.
module phy_skid_pipe
  import phy_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int STAGES = STAGES_DEF,
  localparam int CNT_W  = occ_width(STAGES)
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  occupancy
);

  logic [STAGES:0]   valid_chain_s;
  logic [STAGES:0]   ready_chain_s;
  logic [DATA_W-1:0] data_chain_s [STAGES+1];
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              in_fire_s;
  logic              out_fire_s;

  assign valid_chain_s[0]      = valid_in;
  assign data_chain_s[0]       = data_in;
  assign ready_chain_s[STAGES] = ready_in;

  for (genvar g = 0; g < STAGES; g++) begin : gen_stage
    phy_skid_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk_2f  (clk_2f),
      .reset_L (reset_L),
      .flush   (flush),
      .valid_i (valid_chain_s[g]),
      .data_i  (data_chain_s[g]),
      .ready_o (ready_chain_s[g]),
      .valid_o (valid_chain_s[g+1]),
      .data_o  (data_chain_s[g+1]),
      .ready_i (ready_chain_s[g+1])
    );
  end

  assign ready_out = ready_chain_s[0];
  assign valid_out = valid_chain_s[STAGES];
  assign data_out  = data_chain_s[STAGES];

  // Occupancy next state; flush wins, a simultaneous in/out leaves it unchanged.
  always_comb begin
    in_fire_s  = valid_in & ready_out;
    out_fire_s = valid_out & ready_in;
    occ_d      = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire_s && !out_fire_s) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!in_fire_s && out_fire_s) begin
      occ_d = occ_q - CNT_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
